// File: rtl/inst_fetch_queue_pkg.sv
// Shared widths, reset address and the fetch-entry layout for the instruction
// fetch front end.
package inst_fetch_queue_pkg;

  localparam int INST_ADDR_BUS_W = 32;
  localparam int INST_BUS_W      = 32;

  localparam logic [INST_ADDR_BUS_W-1:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

  typedef logic [INST_ADDR_BUS_W-1:0] inst_addr_t;
  typedef logic [INST_BUS_W-1:0]      inst_t;

  typedef struct packed {
    inst_addr_t pc;
    inst_t      inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_queue_sync_fifo.sv
// Single-clock FIFO with flush, occupancy count and a registered head entry
// visible without a read strobe.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       head_valid,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_pop   = pop & (count_q != '0);
    do_push  = push & ((count_q != CNT_W'(DEPTH)) | do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every use of it.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_valid = (count_q != '0);
  assign head_data  = mem_q[rd_ptr_q];
  assign count      = count_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: sequential fetch PC, fixed-latency SRAM tag
// pipe with credit-based issue, and a decode-side FIFO with redirect flush.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int              ADDR_W   = INST_ADDR_BUS_W,
  parameter int              DATA_W   = INST_BUS_W,
  parameter int              DEPTH    = 4,
  parameter int              SRAM_LAT = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     inst_sram_en,
  output logic [ADDR_W-1:0]        inst_sram_addr,
  input  logic [DATA_W-1:0]        inst_sram_rdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        out_pc,
  output logic [DATA_W-1:0]        out_inst,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam int CNT_W = OCC_W + 1;

  logic [ADDR_W-1:0]        fetch_pc_q, fetch_pc_d;
  logic [SRAM_LAT-1:0]      tag_vld_q, tag_vld_d;
  logic [ADDR_W-1:0]        tag_pc_q [SRAM_LAT];
  logic [ADDR_W-1:0]        tag_pc_d [SRAM_LAT];
  logic [CNT_W-1:0]         inflight;
  logic [CNT_W-1:0]         credit_used;
  logic [OCC_W-1:0]         fifo_count;
  logic [ADDR_W+DATA_W-1:0] head_data;
  logic                     head_valid;
  logic                     flush;
  logic                     issue;
  logic                     pop;
  logic                     push;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < SRAM_LAT; i++) begin
      inflight = inflight + CNT_W'(tag_vld_q[i]);
    end
  end

  assign pop   = head_valid & out_ready;
  assign flush = rst | redirect_valid;

  // Buffered entries plus reads in flight consume credits; a pop this cycle
  // returns one immediately, which is what makes issue depend on out_ready.
  assign credit_used = CNT_W'(fifo_count) + inflight - CNT_W'(pop);
  assign issue       = !flush & (credit_used < CNT_W'(DEPTH));
  assign push        = tag_vld_q[SRAM_LAT-1] & !flush;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    tag_vld_d  = tag_vld_q;
    for (int i = 0; i < SRAM_LAT; i++) begin
      tag_pc_d[i] = tag_pc_q[i];
    end
    tag_vld_d[0] = issue;
    tag_pc_d[0]  = fetch_pc_q;
    for (int i = 1; i < SRAM_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_pc_d[i]  = tag_pc_q[i-1];
    end
    if (issue) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~ADDR_W'(3);
      tag_vld_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      tag_vld_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      tag_vld_q  <= tag_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_pc_q <= tag_pc_d;
  end

  sync_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push       (push),
    .push_data  ({tag_pc_q[SRAM_LAT-1], inst_sram_rdata}),
    .pop        (pop),
    .head_valid (head_valid),
    .head_data  (head_data),
    .count      (fifo_count)
  );

  assign inst_sram_en     = issue;
  assign inst_sram_addr   = fetch_pc_q;
  assign out_valid        = head_valid;
  assign out_pc           = head_data[ADDR_W+DATA_W-1:DATA_W];
  assign out_inst         = head_data[DATA_W-1:0];
  assign occupancy        = fifo_count;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: two instances (SRAM latency 1 and 3) share the
// control stimulus; each has its own SRAM responder and queue-based model.
module tb_inst_fetch_queue;
  import inst_fetch_queue_pkg::*;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  typedef struct packed {
    logic [31:0] pc;
    int unsigned cyc;
  } infl_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_ready = 1'b0;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] sram_word(input logic [31:0] pc);
    return {~pc[15:0], pc[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- DUTs + models
  genvar g;
  for (g = 0; g < 2; g++) begin : u
    localparam int LAT = (g == 0) ? 1 : 3;

    logic        en;
    logic [31:0] addr;
    logic [31:0] rdata = '0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [2:0]  occ;

    logic        h_en   [4];
    logic [31:0] h_addr [4];

    fetch_entry_t ent_q[$];
    infl_t        infl_q[$];
    logic [31:0]  pc_m;
    bit           model_ok = 1'b0;
    int unsigned  t = 0;

    inst_fetch_queue #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .DEPTH    (DEPTH),
      .SRAM_LAT (LAT),
      .RESET_PC (RST_PC)
    ) dut (
      .clk             (clk),
      .rst             (rst),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .inst_sram_en    (en),
      .inst_sram_addr  (addr),
      .inst_sram_rdata (rdata),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_pc          (out_pc),
      .out_inst        (out_inst),
      .occupancy       (occ)
    );

    initial begin
      int           occ_m;
      int           infl_m;
      bit           pop_m;
      bit           en_m;
      fetch_entry_t e;
      infl_t        f;
      forever begin
        @(negedge clk);
        // SRAM responder: data for the request made LAT cycles ago, else junk.
        for (int i = 3; i > 0; i--) begin
          h_en[i]   = h_en[i-1];
          h_addr[i] = h_addr[i-1];
        end
        h_en[0]   = en;
        h_addr[0] = addr;
        rdata = (h_en[LAT] === 1'b1) ? sram_word(h_addr[LAT]) : $urandom();

        if (rst) chk($sformatf("lat%0d_en_in_reset", LAT), {31'b0, en}, 32'd0);

        if (model_ok) begin
          occ_m  = ent_q.size();
          infl_m = infl_q.size();
          pop_m  = (occ_m > 0) && out_ready;
          en_m   = !rst && !redirect_valid && (occ_m + infl_m - (pop_m ? 1 : 0) < DEPTH);
          chk($sformatf("lat%0d_en", LAT), {31'b0, en}, {31'b0, en_m});
          chk($sformatf("lat%0d_addr", LAT), addr, pc_m);
          chk($sformatf("lat%0d_out_valid", LAT), {31'b0, out_valid}, (occ_m > 0) ? 32'd1 : 32'd0);
          chk($sformatf("lat%0d_occupancy", LAT), {29'b0, occ}, occ_m);
          if (occ_m > 0) begin
            chk($sformatf("lat%0d_out_pc", LAT), out_pc, ent_q[0].pc);
            chk($sformatf("lat%0d_out_inst", LAT), out_inst, ent_q[0].inst);
          end

          if (pop_m) void'(ent_q.pop_front());
          if (infl_q.size() > 0 && infl_q[0].cyc + LAT == t) begin
            f = infl_q.pop_front();
            e.pc   = f.pc;
            e.inst = sram_word(f.pc);
            ent_q.push_back(e);
          end
          if (en_m) begin
            f.pc  = pc_m;
            f.cyc = t;
            infl_q.push_back(f);
            pc_m = pc_m + 32'd4;
          end
        end

        if (rst) begin
          ent_q.delete();
          infl_q.delete();
          pc_m     = RST_PC;
          model_ok = 1'b1;
        end else if (redirect_valid) begin
          ent_q.delete();
          infl_q.delete();
          pc_m = {redirect_pc[31:2], 2'b00};
        end
        t++;
      end
    end
  end

  // ---------------------------------------------------------------- driver
  task automatic cyc(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    @(posedge clk);
    #2;
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rpc;
    bit          rdy_bias;

    repeat (3) cyc(1'b1, 1'b0, 32'd0, 1'b0);

    // Streaming from reset with decode always ready.
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    chk("stream_c0_en", {31'b0, u[0].en}, 32'd1);
    chk("stream_c0_addr", u[0].addr, 32'hBFC0_0000);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    chk("stream_c1_addr", u[0].addr, 32'hBFC0_0004);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    chk("stream_c2_valid", {31'b0, u[0].out_valid}, 32'd1);
    chk("stream_c2_pc", u[0].out_pc, 32'hBFC0_0000);
    chk("stream_c2_inst", u[0].out_inst, sram_word(32'hBFC0_0000));
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    chk("stream_c3_pc", u[0].out_pc, 32'hBFC0_0004);
    repeat (8) cyc(1'b0, 1'b0, 32'd0, 1'b1);

    // Backpressure from reset: four requests, then stall.
    cyc(1'b1, 1'b0, 32'd0, 1'b0);
    repeat (8) cyc(1'b0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      chk("bp_en_low", {31'b0, (i == 0) ? u[0].en : u[1].en}, 32'd0);
      chk("bp_addr_hold", (i == 0) ? u[0].addr : u[1].addr, 32'hBFC0_0010);
      chk("bp_occ_full", {29'b0, (i == 0) ? u[0].occ : u[1].occ}, 32'd4);
    end
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    chk("bp_resume_en0", {31'b0, u[0].en}, 32'd1);
    chk("bp_resume_en1", {31'b0, u[1].en}, 32'd1);
    repeat (6) cyc(1'b0, 1'b0, 32'd0, 1'b1);

    // Redirect with two entries buffered and one in flight (latency-1 instance).
    cyc(1'b1, 1'b0, 32'd0, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 32'd0, 1'b0);
    cyc(1'b0, 1'b1, 32'h8000_0104, 1'b0);
    chk("redir_pre_occ", {29'b0, u[0].occ}, 32'd2);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    chk("redir_valid_low", {31'b0, u[0].out_valid}, 32'd0);
    chk("redir_occ_zero", {29'b0, u[0].occ}, 32'd0);
    chk("redir_en", {31'b0, u[0].en}, 32'd1);
    chk("redir_addr", u[0].addr, 32'h8000_0104);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    chk("redir_first_pc", u[0].out_pc, 32'h8000_0104);
    chk("redir_first_inst", u[0].out_inst, sram_word(32'h8000_0104));

    // Address wrap; low redirect bits are ignored.
    cyc(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    chk("wrap_addr0_l1", u[0].addr, 32'hFFFF_FFFC);
    chk("wrap_addr0_l3", u[1].addr, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    chk("wrap_addr1_l1", u[0].addr, 32'h0000_0000);
    chk("wrap_addr1_l3", u[1].addr, 32'h0000_0000);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    chk("wrap_out0", u[0].out_pc, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    chk("wrap_out1", u[0].out_pc, 32'h0000_0000);

    // Reset mid-stream with reads in flight on the latency-3 instance.
    repeat (10) cyc(1'b0, 1'b0, 32'd0, 1'b1);
    cyc(1'b1, 1'b0, 32'd0, 1'b1);
    cyc(1'b0, 1'b0, 32'd0, 1'b1);
    chk("midrst_valid", {31'b0, u[1].out_valid}, 32'd0);
    chk("midrst_occ", {29'b0, u[1].occ}, 32'd0);
    chk("midrst_addr", u[1].addr, RST_PC);
    chk("midrst_en", {31'b0, u[1].en}, 32'd1);
    repeat (6) cyc(1'b0, 1'b0, 32'd0, 1'b1);

    // Randomized traffic with bursts of backpressure.
    rdy_bias = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (n % 64 == 0) rdy_bias = ($urandom_range(0, 2) != 0);
      rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
      cyc(($urandom_range(0, 99) == 0),
          ($urandom_range(0, 19) == 0),
          rpc,
          rdy_bias ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 4) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Parametrised instruction-fetch front end between the PC generator and the IF/ID pipeline register. It issues one instruction-SRAM read per cycle from a sequential fetch PC and tracks reads in flight across a fixed SRAM latency. Returned instructions are buffered with their PCs in a FIFO and delivered to decode through a valid/ready handshake. A redirect (branch, jump, exception) flushes all buffered and in-flight fetches and restarts at a new PC.

## Interface
Parameters:
- ADDR_W, 32, instruction address width
- DATA_W, 32, instruction width
- DEPTH, 4, FIFO entries; power of two, ≥2
- SRAM_LAT, 1, cycles from `inst_sram_en` to valid `inst_sram_rdata`; legal range 1..3
- RESET_PC, 32'hBFC0_0000, first fetch address after reset

Ports (reset is synchronous and active-high):
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- redirect_valid  in  1  flush and restart fetch at `redirect_pc`
- redirect_pc  in  ADDR_W  restart address; low 2 bits are ignored and treated as 0
- inst_sram_en  out  1  read request this cycle
- inst_sram_addr  out  ADDR_W  read address; always equals the fetch PC
- inst_sram_rdata  in  DATA_W  read data, valid SRAM_LAT cycles after the request
- out_valid  out  1  head entry valid
- out_ready  in  1  decode accepts the head entry
- out_pc  out  ADDR_W  PC of the head entry
- out_inst  out  DATA_W  instruction of the head entry
- occupancy  out  $clog2(DEPTH)+1  number of FIFO entries

## Operation
- State:
  - fetch_pc
  - FIFO of {pc, inst}
  - SRAM_LAT-stage tag pipe of {valid, pc}
  - inflight = popcount of valid bits in the tag pipe
- pop = out_valid & out_ready.
- issue = !rst & !redirect_valid & (occupancy + inflight − pop < DEPTH).
  - inst_sram_en = issue. This is combinational in out_ready.
- On issue:
  - stage 0 of the tag pipe ← {1, fetch_pc}
  - fetch_pc ← fetch_pc + 4, wrapping modulo 2^ADDR_W
- When there is no issue, stage 0 ← {0, x}. The tag pipe shifts every cycle.
- When the last tag stage is valid, {tag.pc, inst_sram_rdata} is pushed into the FIFO. The credit rule above guarantees the push never overflows.
- On redirect_valid:
  - all FIFO entries and all tag-pipe valid bits are cleared
  - fetch_pc ← {redirect_pc[ADDR_W-1:2], 2'b00}
  - data returned from killed requests is discarded
- Redirect and pop in the same cycle: the pop counts as accepted by decode, then the flush applies.
- Redirect and push in the same cycle: the push is dropped.
- Push and pop in the same cycle: occupancy is unchanged.
- out_* present the FIFO head. There is no bypass from the SRAM to the output.

## Timing
- Reset values, applied on the cycle `rst` is sampled high:
  - fetch_pc = inst_sram_addr = RESET_PC
  - inst_sram_en = 0
  - out_valid = 0
  - occupancy = 0
  - all tag valid bits = 0
  - out_pc and out_inst are don't-care while out_valid = 0
- Reset mid-operation behaves exactly like a redirect to RESET_PC and additionally blocks issue in that cycle.
- Issue to out_valid: SRAM_LAT + 1 cycles. With SRAM_LAT = 1, a request issued in cycle n is pushed at the end of cycle n+1, and out_valid rises in cycle n+2.
- After a redirect in cycle n, the first request is issued in cycle n+1 at the new PC.
- Throughput with out_ready held high is one instruction per cycle, provided DEPTH ≥ SRAM_LAT + 1.
- Full condition: no issue occurs while occupancy + inflight − pop = DEPTH. inst_sram_addr holds its value while issue is 0.

## Structure
- The shared package defines:
  - RESET_PC default
  - InstAddrBus and InstBus widths
  - the fetch-entry struct {pc, inst}
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH) with:
  - flush
  - push/pop
  - count
  - head output
- The tag pipe, credit check and fetch_pc register live in the top module.

## Test plan
- Reset, then stream with out_ready = 1 and SRAM_LAT = 1 (DEPTH = 4):
  - first en at RESET_PC in cycle 0
  - out_valid in cycle 2 with out_pc = BFC0_0000
  - then BFC0_0004, 0008, … one per cycle
- Backpressure with out_ready = 0 (DEPTH = 4):
  - exactly 4 requests are issued, then en = 0 and addr holds BFC0_0010
  - occupancy saturates at 4
  - raising out_ready resumes issue the same cycle, with no lost or duplicated PCs
- Redirect to 8000_0104 with 2 entries buffered and 1 in flight:
  - next-cycle out_valid = 0 and occupancy = 0
  - the killed response is not pushed
  - en at 8000_0104 next cycle; its data appears on out_* SRAM_LAT + 1 cycles later
- Redirect and pop coincide: the popped entry is counted delivered once, and no stale PC ever appears after the redirect.
- Wrap with ADDR_W = 32, redirect to FFFF_FFFC: fetch order is FFFF_FFFC then 0000_0000.
- Reset mid-stream with SRAM_LAT = 3: all outputs return to reset values the next cycle, and the in-flight responses arriving afterward are discarded.
